// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a UART transmitter: grants one byte
// per frame, watches for a missing tx_done_tick and spaces frames by s_tick gaps.
module uart_tx_arbiter #(
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       req0,
  input  logic [7:0] din0,
  input  logic       req1,
  input  logic [7:0] din1,
  output logic       ack0,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_din,
  input  logic       tx_done_tick,
  output logic       busy,
  output logic       grant_id,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  localparam bit         HAS_GAP      = (GAP_TICKS > 0);
  localparam logic [8:0] TIMEOUT_LAST = 9'(TIMEOUT_TICKS - 1);
  localparam logic [8:0] GAP_LAST     = HAS_GAP ? 9'(GAP_TICKS - 1) : 9'd0;

  state_t     state_reg;
  logic [8:0] cnt_reg;
  logic       last_grant_reg;
  logic       pick1;

  // On a tie, the requester that was not served last wins.
  assign pick1 = req1 && (!req0 || !last_grant_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 9'd0;
      last_grant_reg <= 1'b1;
      tx_din         <= 8'h00;
      grant_id       <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      tx_start       <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            tx_din    <= pick1 ? din1 : din0;
            grant_id  <= pick1;
            ack0      <= !pick1;
            ack1      <= pick1;
            busy      <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          tx_start  <= 1'b1;
          cnt_reg   <= 9'd0;
          state_reg <= BUSY;
        end
        BUSY: begin
          // A completing frame takes priority over a simultaneous timeout.
          if (tx_done_tick || (s_tick && cnt_reg == TIMEOUT_LAST)) begin
            timeout_err    <= !tx_done_tick;
            last_grant_reg <= grant_id;
            cnt_reg        <= 9'd0;
            if (HAS_GAP) begin
              state_reg <= GAP;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else if (s_tick) begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        GAP: begin
          if (s_tick) begin
            if (cnt_reg == GAP_LAST) begin
              cnt_reg   <= 9'd0;
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 9'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
